// File: rtl/steering_pkg.sv
// Shared types and helpers for the steering command conditioner.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package steering_pkg;

   // Controller mode: follow navigation targets, or drive the wheel home.
   typedef enum logic [0:0] {
      TRACK  = 1'b0,
      HOMING = 1'b1
   } state_t;

   // Clamp a requested direction into [lo, hi].
   // Values are carried as 32-bit unsigned so any WIDTH up to 32 fits.
   function automatic int unsigned clamp_pos(
      input int unsigned val,
      input int unsigned lo,
      input int unsigned hi
   );
      int unsigned res;
      res = val;
      if (val < lo) begin
         res = lo;
      end else if (val > hi) begin
         res = hi;
      end
      return res;
   endfunction

endpackage

// File: rtl/steering_slew_ctrl_tick_gen.sv
// Prescaler producing a one-cycle update tick every TICK_DIV clocks.
// Latency: first tick TICK_DIV cycles after reset release, then periodic.
// Backpressure: none; the tick is free-running and never stalls.
module tick_gen #(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic CLOCK_50,
   input  logic reset_n,
   output logic tick
);

   localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // Count 0..TICK_DIV-1 and wrap; the wrap cycle is the tick.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Tick is decoded from the counter register only, so it is glitch-free
   // with respect to the other inputs and lands on the wrap cycle.
   assign tick = (cnt == LAST);

endmodule

// File: rtl/steering_slew_ctrl.sv
// Rate-limited steering command conditioner with homing sequence.
// Latency: target -> goal 1 cycle; movement on next tick, output 1 cycle after tick.
// Backpressure: while cmd_valid is unaccepted, ticks are skipped (not queued).
module steering_slew_ctrl
   import steering_pkg::*;
#(
   parameter int unsigned WIDTH      = 9,
   parameter int unsigned MIN_POS    = 64,
   parameter int unsigned MAX_POS    = 448,
   parameter int unsigned CENTER_POS = 256,
   parameter int unsigned STEP_MAX   = 4,
   parameter int unsigned TICK_DIV   = 50000
) (
   input  logic             CLOCK_50,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] targetDirection,
   input  logic             target_valid,
   input  logic             reset_Pos,
   output logic [WIDTH-1:0] targetDirection_Ard,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic             reset_Pos_Ard,
   output logic             at_target
);

   localparam logic [WIDTH-1:0] CENTER_W = WIDTH'(CENTER_POS);
   localparam logic [WIDTH:0]   STEP_W   = (WIDTH + 1)'(STEP_MAX);

   // Architectural state.
   state_t           state;
   logic [WIDTH-1:0] goal;
   logic [WIDTH-1:0] cur;
   logic             pending;

   // Update tick from the prescaler.
   logic             tick;

   // Slew datapath.
   logic signed [WIDTH:0] diff;
   logic                  diff_nz;
   logic                  diff_neg;
   logic [WIDTH:0]        mag;
   logic [WIDTH-1:0]      step;
   logic [WIDTH-1:0]      cur_next;
   logic [WIDTH-1:0]      goal_in;

   // Handshake and mode qualifiers.
   logic accept;
   logic issue;
   logic home_done;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .tick     (tick)
   );

   // Clamp the requested direction into the legal mechanical range.
   always_comb begin
      goal_in = WIDTH'(clamp_pos(32'(targetDirection), MIN_POS, MAX_POS));
   end

   // Signed distance to goal and the bounded step toward it.
   always_comb begin
      diff     = $signed({1'b0, goal}) - $signed({1'b0, cur});
      diff_nz  = (diff != '0);
      diff_neg = diff[WIDTH];
      // Magnitude computed directly from the operands avoids negating diff.
      if (diff_neg) begin
         mag = {1'b0, cur} - {1'b0, goal};
      end else begin
         mag = {1'b0, goal} - {1'b0, cur};
      end
      // mag never exceeds 2^WIDTH-1, so the step always fits in WIDTH bits.
      if (mag > STEP_W) begin
         step = STEP_W[WIDTH-1:0];
      end else begin
         step = mag[WIDTH-1:0];
      end
      if (diff_neg) begin
         cur_next = cur - step;
      end else begin
         cur_next = cur + step;
      end
   end

   // Handshake qualifiers: an accept cycle can never also issue, because
   // issue requires pending low while accept requires it high.
   always_comb begin
      accept    = pending & cmd_ready;
      issue     = tick & ~pending & diff_nz;
      home_done = (cur == CENTER_W) & ~pending & ~reset_Pos;
   end

   // Mode FSM and goal register; homing request beats a same-cycle target.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state <= TRACK;
         goal  <= CENTER_W;
      end else begin
         case (state)
            TRACK: begin
               if (reset_Pos) begin
                  state <= HOMING;
                  goal  <= CENTER_W;
               end else if (target_valid) begin
                  goal <= goal_in;
               end
            end
            HOMING: begin
               // Targets are dropped here; goal stays at centre throughout.
               goal <= CENTER_W;
               if (home_done) begin
                  state <= TRACK;
               end
            end
            default: begin
               state <= TRACK;
               goal  <= CENTER_W;
            end
         endcase
      end
   end

   // Position and pending-command register: step on a free tick, clear on accept.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         cur     <= CENTER_W;
         pending <= 1'b0;
      end else if (accept) begin
         pending <= 1'b0;
      end else if (issue) begin
         cur     <= cur_next;
         pending <= 1'b1;
      end
   end

   // Every output is decoded from registers only, never from an input.
   assign targetDirection_Ard = cur;
   assign cmd_valid           = pending;
   assign reset_Pos_Ard       = (state == HOMING);
   assign at_target           = (cur == goal) & ~pending;

endmodule

// File: tb/tb_steering_slew_ctrl.sv
module tb_steering_slew_ctrl;

   localparam int TDIV = 4;

   logic       CLOCK_50;
   logic       reset_n;
   logic [8:0] targetDirection;
   logic       target_valid;
   logic       reset_Pos;
   logic [8:0] targetDirection_Ard;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       reset_Pos_Ard;
   logic       at_target;

   int n_total = 0;
   int n_bad   = 0;
   int mdl_cur;
   int mdl_goal;

   typedef struct {
      int targ;
      int goal;
      int first;
      int count;
   } vec_t;

   vec_t vecs[5];

   steering_slew_ctrl #(
      .WIDTH      (9),
      .MIN_POS    (64),
      .MAX_POS    (448),
      .CENTER_POS (256),
      .STEP_MAX   (4),
      .TICK_DIV   (TDIV)
   ) dut (
      .CLOCK_50            (CLOCK_50),
      .reset_n             (reset_n),
      .targetDirection     (targetDirection),
      .target_valid        (target_valid),
      .reset_Pos           (reset_Pos),
      .targetDirection_Ard (targetDirection_Ard),
      .cmd_valid           (cmd_valid),
      .cmd_ready           (cmd_ready),
      .reset_Pos_Ard       (reset_Pos_Ard),
      .at_target           (at_target)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic int model_step(input int c, input int g);
      if (g > c) return (g - c > 4) ? c + 4 : g;
      if (g < c) return (c - g > 4) ? c - 4 : g;
      return c;
   endfunction

   // One-cycle target strobe (optionally with a homing request in the same cycle).
   task automatic strobe(input int t, input bit rp);
      @(negedge CLOCK_50);
      targetDirection = 9'(t);
      target_valid    = 1'b1;
      reset_Pos       = rp;
      @(negedge CLOCK_50);
      target_valid    = 1'b0;
      reset_Pos       = 1'b0;
   endtask

   // Follow commands (cmd_ready assumed high) until at_target, checking each one.
   task automatic run_track(input int budget, input bit home,
                            output int ncmd, output int first, output int last);
      ncmd  = 0;
      first = -1;
      last  = -1;
      for (int c = 0; c < budget; c++) begin
         @(negedge CLOCK_50);
         if (cmd_valid) begin
            mdl_cur = model_step(mdl_cur, mdl_goal);
            chk("cmd_step", int'(targetDirection_Ard), mdl_cur);
            if (home) chk("home_flag", int'(reset_Pos_Ard), 1);
            if (ncmd == 0) first = int'(targetDirection_Ard);
            last = int'(targetDirection_Ard);
            ncmd++;
         end
         if (at_target) break;
      end
      chk("converge", int'(at_target), 1);
   endtask

   task automatic wait_valid(input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge CLOCK_50);
         if (cmd_valid) break;
      end
   endtask

   initial begin
      int ncmd, first, last, bad_hold, gap, extra;

      vecs[0] = '{270, 270, 260,  4};
      vecs[1] = '{500, 448, 274, 45};
      vecs[2] = '{ 10,  64, 444, 96};
      vecs[3] = '{257, 257,  68, 49};
      vecs[4] = '{256, 256, 256,  1};

      reset_n         = 1'b0;
      targetDirection = '0;
      target_valid    = 1'b0;
      reset_Pos       = 1'b0;
      cmd_ready       = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      chk("rst_pos",    int'(targetDirection_Ard), 256);
      chk("rst_valid",  int'(cmd_valid), 0);
      chk("rst_home",   int'(reset_Pos_Ard), 0);
      chk("rst_attgt",  int'(at_target), 1);
      reset_n = 1'b1;
      mdl_cur = 256;

      // Table-driven slew and clamp vectors, cmd_ready tied high.
      for (int i = 0; i < 5; i++) begin
         strobe(vecs[i].targ, 1'b0);
         mdl_goal = vecs[i].goal;
         run_track(vecs[i].count * TDIV + 20, 1'b0, ncmd, first, last);
         chk($sformatf("vec%0d_first", i), first, vecs[i].first);
         chk($sformatf("vec%0d_final", i), last,  vecs[i].goal);
         chk($sformatf("vec%0d_count", i), ncmd,  vecs[i].count);
      end

      // Backpressure: hold 260 for three ticks, then exactly one step to 264.
      cmd_ready = 1'b0;
      strobe(300, 1'b0);
      mdl_goal = 300;
      wait_valid(3 * TDIV);
      chk("bp_valid", int'(cmd_valid), 1);
      chk("bp_first", int'(targetDirection_Ard), 260);
      bad_hold = 0;
      for (int c = 0; c < 3 * TDIV; c++) begin
         @(negedge CLOCK_50);
         if (!cmd_valid || targetDirection_Ard != 9'd260) bad_hold++;
      end
      chk("bp_hold", bad_hold, 0);
      cmd_ready = 1'b1;
      @(negedge CLOCK_50);
      chk("bp_release", int'(cmd_valid), 0);
      gap = 0;
      for (int c = 0; c < 2 * TDIV; c++) begin
         @(negedge CLOCK_50);
         gap++;
         if (cmd_valid) break;
      end
      chk("bp_next", int'(targetDirection_Ard), 264);
      chk("bp_gap_ok", int'(gap <= TDIV), 1);
      mdl_cur = 264;
      run_track(20 * TDIV, 1'b0, ncmd, first, last);
      chk("bp_final", last, 300);

      // Homing: reset_Pos and a target in the same cycle; target must be dropped.
      strobe(400, 1'b1);
      chk("home_entry", int'(reset_Pos_Ard), 1);
      mdl_goal = 256;
      run_track(20 * TDIV, 1'b1, ncmd, first, last);
      chk("home_first", first, 296);
      chk("home_final", last, 256);
      chk("home_count", ncmd, 11);
      chk("home_hold", int'(reset_Pos_Ard), 1);
      @(negedge CLOCK_50);
      chk("home_exit", int'(reset_Pos_Ard), 0);
      extra = 0;
      for (int c = 0; c < 3 * TDIV; c++) begin
         @(negedge CLOCK_50);
         if (cmd_valid) extra++;
      end
      chk("home_drop", extra, 0);
      chk("home_pos", int'(targetDirection_Ard), 256);

      // Retarget while a command is pending: last target wins, next step is down.
      cmd_ready = 1'b0;
      strobe(300, 1'b0);
      wait_valid(3 * TDIV);
      chk("rt_pend", int'(targetDirection_Ard), 260);
      strobe(200, 1'b0);
      repeat (2 * TDIV) @(negedge CLOCK_50);
      chk("rt_held", int'(targetDirection_Ard), 260);
      cmd_ready = 1'b1;
      mdl_cur  = 260;
      mdl_goal = 200;
      run_track(30 * TDIV, 1'b0, ncmd, first, last);
      chk("rt_first", first, 256);
      chk("rt_final", last, 200);
      chk("rt_count", ncmd, 15);

      // Reset in the middle of a pending command.
      cmd_ready = 1'b0;
      strobe(300, 1'b0);
      wait_valid(3 * TDIV);
      chk("mr_pend", int'(cmd_valid), 1);
      reset_n = 1'b0;
      @(negedge CLOCK_50);
      chk("mr_pos",   int'(targetDirection_Ard), 256);
      chk("mr_valid", int'(cmd_valid), 0);
      chk("mr_home",  int'(reset_Pos_Ard), 0);
      chk("mr_attgt", int'(at_target), 1);
      reset_n = 1'b1;
      repeat (2 * TDIV) @(negedge CLOCK_50);
      chk("mr_idle", int'(cmd_valid), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
